// File: rtl/axis_peak_capture.sv
// axis_peak_capture
//
// Multi-channel AXI-stream burst capture that fires when any enabled channel's
// magnitude exceeds a runtime multiple of its own running average. Each
// burst is BURST_LENGTH beats long: PRE_TRIGGER beats before the trigger
// beat, the trigger beat itself, and the beats that follow it.
//
// Ports
//   clk               single clock
//   rst_n             synchronous active-low reset
//   thresh_shift      threshold multiplier exponent, sampled per accepted beat
//   chan_mask         per-channel trigger enable
//   s_axis_*          input stream; tdata_abs carries the magnitudes aligned to tdata
//   m_axis_*          output burst stream; tuser is the hit vector of the trigger beat
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FILL  | collecting pre-trigger history / holdoff, triggers ignored
// S_ARMED | waiting for a beat whose magnitude crosses the threshold
// S_POST  | capturing the beats that follow the trigger
// S_DRAIN | input stalled, emitting the buffered burst
module axis_peak_capture #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHANNEL_WIDTH = 64,
  parameter int BURST_LENGTH  = 32,
  parameter int PRE_TRIGGER   = 16,
  parameter int AVG_POWER     = 4,
  parameter int HOLDOFF       = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [3:0]                              thresh_shift,
  input  logic [NUM_CHANNELS-1:0]                 chan_mask,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   s_axis_tdata_abs,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_CHANNELS-1:0]                 m_axis_tuser,
  output logic                                    m_axis_tlast
);

  localparam int DW         = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int PW         = $clog2(BURST_LENGTH);
  localparam int SW         = CHANNEL_WIDTH + AVG_POWER;
  localparam int TW         = CHANNEL_WIDTH + 16;
  localparam int AVG_LEN    = 1 << AVG_POWER;
  localparam int HPW        = (AVG_POWER > 0) ? AVG_POWER : 1;
  localparam int FILL_BEATS = (PRE_TRIGGER > HOLDOFF) ? PRE_TRIGGER : HOLDOFF;
  localparam int FCW        = $clog2(FILL_BEATS + 1);
  localparam int POST_INIT  = BURST_LENGTH - PRE_TRIGGER - 1;
  localparam int POST_CW    = $clog2(POST_INIT + 1);

  typedef enum logic [1:0] {S_FILL, S_ARMED, S_POST, S_DRAIN} state_t;

  state_t                state;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         beat_cnt;
  logic [FCW-1:0]        fill_cnt;
  logic [POST_CW-1:0]    post_cnt;
  logic [DW-1:0]         mem [BURST_LENGTH];

  logic [SW-1:0]            sum  [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0] hist [NUM_CHANNELS][AVG_LEN];
  logic [HPW-1:0]           hist_ptr;

  logic                    accept;
  logic [NUM_CHANNELS-1:0] hit;

  assign accept = s_axis_tvalid & s_axis_tready;

  // Threshold is formed in TW bits so (avg + 1) << 15 can never overflow.
  function automatic logic ch_hit(input logic [SW-1:0]            sum_v,
                                  input logic [CHANNEL_WIDTH-1:0] mag,
                                  input logic [3:0]               shift);
    logic [TW-1:0] avg_w;
    logic [TW-1:0] thr;
    avg_w = TW'(sum_v >> AVG_POWER);
    thr   = (avg_w + TW'(1)) << shift;
    return TW'(mag) > thr;
  endfunction

  // Uses the average from before the current beat enters the window.
  always_comb begin
    hit = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      hit[n] = chan_mask[n] &
               ch_hit(sum[n], s_axis_tdata_abs[n*CHANNEL_WIDTH +: CHANNEL_WIDTH], thresh_shift);
    end
  end

  // Boxcar average: add the new magnitude, drop the one leaving the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_ptr <= '0;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        sum[n] <= '0;
        for (int k = 0; k < AVG_LEN; k++) begin
          hist[n][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        sum[n] <= sum[n]
                  + SW'(s_axis_tdata_abs[n*CHANNEL_WIDTH +: CHANNEL_WIDTH])
                  - SW'(hist[n][hist_ptr]);
        hist[n][hist_ptr] <= s_axis_tdata_abs[n*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
      hist_ptr <= (AVG_POWER == 0) ? '0 : hist_ptr + 1'b1;
    end
  end

  // Capture buffer: distributed RAM, async read, no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      beat_cnt      <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case (state)
        S_FILL: begin
          s_axis_tready <= 1'b1;
          if (accept) begin
            if (fill_cnt == FCW'(FILL_BEATS - 1)) begin
              fill_cnt <= '0;
              state    <= S_ARMED;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (accept && (hit != '0)) begin
            m_axis_tuser <= hit;
            post_cnt     <= POST_CW'(POST_INIT);
            state        <= S_POST;
          end
        end
        S_POST: begin
          if (accept) begin
            if ((post_cnt == '0) || (post_cnt == POST_CW'(1))) begin
              post_cnt      <= '0;
              // Slot after the final write holds the oldest beat of the burst.
              rd_ptr        <= wr_ptr + 1'b1;
              beat_cnt      <= '0;
              s_axis_tready <= 1'b0;
              state         <= S_DRAIN;
            end else begin
              post_cnt <= post_cnt - 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            fill_cnt      <= '0;
            s_axis_tready <= 1'b1;
            state         <= S_FILL;
          end else if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= mem[rd_ptr];
            m_axis_tlast  <= (beat_cnt == PW'(BURST_LENGTH - 1));
            rd_ptr        <= rd_ptr + 1'b1;
            beat_cnt      <= beat_cnt + 1'b1;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
